// File: rtl/add_pipe_stage.sv
// add_pipe_stage: two-stage pipelined unsigned adder with valid/ready handshakes.
// Stage 1 holds the operand pair, stage 2 holds the registered sum and carry.
// The pipeline holds up to two pairs, keeps them in order under backpressure,
// and counts consumed results with a saturating counter.
module add_pipe_stage #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       y,
  output logic                 carry,
  output logic [CNT_WIDTH-1:0] txn_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     a1_q, a1_d;
  logic [WIDTH-1:0]     b1_q, b1_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH:0]       y_q, y_d;
  logic                 carry_q, carry_d;
  logic [CNT_WIDTH-1:0] txn_count_q, txn_count_d;

  logic                 s1_adv;
  logic                 in_xfer;
  logic                 out_xfer;
  logic [WIDTH:0]       sum;

  // Handshake decode: stage 1 moves forward when stage 2 is empty or draining,
  // so a full pipeline can still accept a new pair on the same edge.
  always_comb begin
    s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s1_adv;
    in_xfer  = in_valid && in_ready;
    out_xfer = s2_valid_q && out_ready;
  end

  // Next-state logic: a load sets a stage's valid and takes priority over the clear.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    s2_valid_d  = s2_valid_q;
    y_d         = y_q;
    carry_d     = carry_q;
    txn_count_d = txn_count_q;
    sum         = {1'b0, a1_q} + {1'b0, b1_q};

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      a1_d       = a;
      b1_d       = b;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      y_d        = sum;
      carry_d    = sum[WIDTH];
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (out_xfer && (txn_count_q != CNT_MAX)) begin
      txn_count_d = txn_count_q + CNT_ONE;
    end
  end

  // Pipeline registers; reset empties both stages and clears all payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      s2_valid_q  <= 1'b0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      txn_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      s2_valid_q  <= s2_valid_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign carry     = carry_q;
  assign txn_count = txn_count_q;

endmodule
